// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions used by the ahb_slave memory slave and the ahb_m traffic master.
// Contents: transfer-type, burst and size enums, response constants, and the
// transfer legality check applied to every captured address phase.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_t;

  typedef enum logic [2:0] {
    HSIZE_8    = 3'b000,
    HSIZE_16   = 3'b001,
    HSIZE_32   = 3'b010,
    HSIZE_64   = 3'b011,
    HSIZE_128  = 3'b100,
    HSIZE_256  = 3'b101,
    HSIZE_512  = 3'b110,
    HSIZE_1024 = 3'b111
  } hsize_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // A transfer is legal when it fits the bus, is size-aligned and lands inside the RAM.
  // Everything is widened to 64 bits so callers with any address width share one function.
  function automatic logic xfer_legal(input logic [2:0]  hsize,
                                      input logic [63:0] haddr,
                                      input logic [63:0] bus_bytes,
                                      input logic [63:0] mem_bytes);
    logic [63:0] nbytes;
    nbytes = 64'd1 << hsize;
    return (nbytes <= bus_bytes) && ((haddr & (nbytes - 64'd1)) == 64'd0) &&
           (haddr < mem_bytes);
  endfunction

endpackage

// File: rtl/ahb_slave_ram.sv
// Single-port RAM for the AHB slave: per-byte write enable, asynchronous read.
// Ports:
//   clk_i   - write clock
//   we_i    - write enable
//   be_i    - byte-lane enables (little-endian lanes)
//   addr_i  - word address, shared by read and write
//   wdata_i - write data
//   rdata_o - combinational read of the addressed word
// Contents are not reset.
module ahb_slave_ram #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Depth     = 512,
  parameter int unsigned AddrW     = 9
) (
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [DataWidth/8-1:0] be_i,
  input  logic [AddrW-1:0]       addr_i,
  input  logic [DataWidth-1:0]   wdata_i,
  output logic [DataWidth-1:0]   rdata_o
);

  logic [DataWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned b = 0; b < DataWidth / 8; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_slave.sv
// AHB-Lite memory slave backed by a byte-addressable RAM.
// Ports:
//   HCLK    - clock, rising edge
//   HRESETn - synchronous reset, active-high (1 = reset) despite the name
//   HADDR, HWDATA, HWRITE, HSIZE, HBURST, HTRANS - AHB master inputs (HBURST unused)
//   HREADY  - shared transfer-complete / bus-ready
//   HRDATA  - read data, held outside read data phases
//   HRESP   - 0 OKAY, 1 ERROR (two-cycle error response)
//   HEXOKAY - exclusives unsupported, always 0
module ahb_slave
  import ahb_pkg::*;
#(
  parameter int unsigned AHB_DATA_WIDTH    = 64,
  parameter int unsigned AHB_ADDRESS_WIDTH = 32,
  parameter int unsigned MEM_BYTES         = 4096,
  parameter int unsigned WAIT_STATES       = 0
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic [AHB_ADDRESS_WIDTH-1:0] HADDR,
  input  logic [AHB_DATA_WIDTH-1:0]    HWDATA,
  input  logic                         HWRITE,
  input  logic [2:0]                   HSIZE,
  input  logic [2:0]                   HBURST,
  input  logic [1:0]                   HTRANS,
  output logic                         HREADY,
  output logic [AHB_DATA_WIDTH-1:0]    HRDATA,
  output logic                         HRESP,
  output logic                         HEXOKAY
);

  localparam int unsigned BusBytes  = AHB_DATA_WIDTH / 8;
  localparam int unsigned ByteOffW  = $clog2(BusBytes);
  localparam int unsigned MemAddrW  = $clog2(MEM_BYTES);
  localparam int unsigned Words     = MEM_BYTES / BusBytes;
  localparam int unsigned WordAddrW = MemAddrW - ByteOffW;
  localparam int unsigned WaitW     = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  state_e                    state_q, state_d;
  logic [MemAddrW-1:0]       addr_q, addr_d;
  logic                      write_q, write_d;
  logic [2:0]                size_q, size_d;
  logic [WaitW-1:0]          wait_q, wait_d;
  logic [AHB_DATA_WIDTH-1:0] hrdata_q, hrdata_d;

  logic                      hready;
  logic                      capture;
  logic                      legal;
  logic                      read_phase;
  logic                      ram_we;
  logic [BusBytes-1:0]       ram_be;
  logic [AHB_DATA_WIDTH-1:0] ram_rdata;
  logic [31:0]               lane_lo, lane_hi;

  assign hready     = !(state_q inside {StWait, StErr1});
  assign capture    = hready && HTRANS[1];
  assign legal      = xfer_legal(HSIZE, 64'(HADDR), 64'(BusBytes), 64'(MEM_BYTES));
  assign read_phase = (state_q == StData) && !write_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    size_d   = size_q;
    wait_d   = wait_q;
    hrdata_d = hrdata_q;

    unique case (state_q)
      StWait: begin
        if (wait_q == '0) begin
          state_d = StData;
        end else begin
          wait_d = wait_q - WaitW'(1);
        end
      end
      StErr1:  state_d = StErr2;
      // Idle, Data and Err2 all complete this cycle; a capture below overrides.
      default: state_d = StIdle;
    endcase

    // Remember the returned word so HRDATA holds it once the read phase ends.
    if (read_phase) begin
      hrdata_d = ram_rdata;
    end

    if (capture) begin
      addr_d  = HADDR[MemAddrW-1:0];
      write_d = HWRITE;
      size_d  = HSIZE;
      if (!legal) begin
        state_d = StErr1;
      end else if (WAIT_STATES == 0) begin
        state_d = StData;
      end else begin
        state_d = StWait;
        wait_d  = WaitW'(WAIT_STATES - 1);
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESETn) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
      wait_q   <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      size_q   <= size_d;
      wait_q   <= wait_d;
      hrdata_q <= hrdata_d;
    end
  end

  // Byte lanes [offset, offset + size) of the addressed word.
  always_comb begin
    lane_lo = 32'(addr_q[ByteOffW-1:0]);
    lane_hi = lane_lo + (32'd1 << size_q);
    ram_be  = '0;
    for (int unsigned b = 0; b < BusBytes; b++) begin
      ram_be[b] = (b >= lane_lo) && (b < lane_hi);
    end
  end

  // Reset in the same cycle abandons the pending write.
  assign ram_we = (state_q == StData) && write_q && !HRESETn;

  ahb_slave_ram #(
    .DataWidth(AHB_DATA_WIDTH),
    .Depth    (Words),
    .AddrW    (WordAddrW)
  ) u_ram (
    .clk_i  (HCLK),
    .we_i   (ram_we),
    .be_i   (ram_be),
    .addr_i (addr_q[MemAddrW-1:ByteOffW]),
    .wdata_i(HWDATA),
    .rdata_o(ram_rdata)
  );

  assign HREADY  = hready;
  assign HRESP   = (state_q inside {StErr1, StErr2}) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA  = read_phase ? ram_rdata : hrdata_q;
  assign HEXOKAY = 1'b0;

  // The master supplies every address, so burst type and BUSY-vs-IDLE carry no information.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HTRANS[0]};

endmodule

// File: tb/tb_ahb_slave.sv
// Self-checking bench for ahb_slave: a zero-wait instance and a two-wait-state instance share
// the master inputs; a byte-array model of the RAM supplies all expected read data.
module tb_ahb_slave;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic [31:0] HADDR = '0;
  logic [63:0] HWDATA = '0;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = '0;
  logic [2:0]  HBURST = '0;
  logic [1:0]  HTRANS = '0;

  logic        hready_0, hresp_0, hexokay_0;
  logic [63:0] hrdata_0;
  logic        hready_w, hresp_w, hexokay_w;
  logic [63:0] hrdata_w;

  always #5 HCLK = ~HCLK;

  ahb_slave #(.AHB_DATA_WIDTH(64), .AHB_ADDRESS_WIDTH(32), .MEM_BYTES(4096),
              .WAIT_STATES(0)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HREADY(hready_0), .HRDATA(hrdata_0),
    .HRESP(hresp_0), .HEXOKAY(hexokay_0)
  );

  ahb_slave #(.AHB_DATA_WIDTH(64), .AHB_ADDRESS_WIDTH(32), .MEM_BYTES(4096),
              .WAIT_STATES(2)) dut_ws (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HREADY(hready_w), .HRDATA(hrdata_w),
    .HRESP(hresp_w), .HEXOKAY(hexokay_w)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic [63:0] wdata;
  } xfer_t;

  xfer_t       q[$];
  logic [63:0] res_rdata [256];
  int          res_stall [256];
  logic        res_resp  [256];
  logic        res_early [256];
  bit          seq_timeout;

  // ---------------- reference model ----------------
  logic [7:0] mem_m [4096];

  function automatic bit m_legal(input logic [31:0] a, input logic [2:0] s);
    int unsigned n;
    n = 32'd1 << s;
    return (n <= 8) && ((a % n) == 0) && (a < 4096);
  endfunction

  function automatic void m_write(input logic [31:0] a, input logic [2:0] s,
                                  input logic [63:0] d);
    int unsigned n;
    n = 32'd1 << s;
    for (int unsigned k = 0; k < n; k++) mem_m[a + k] = d[8 * ((a % 8) + k) +: 8];
  endfunction

  function automatic logic [63:0] m_read(input logic [31:0] a);
    logic [63:0] r;
    for (int unsigned k = 0; k < 8; k++) r[8*k +: 8] = mem_m[(a & ~32'd7) + k];
    return r;
  endfunction

  function automatic xfer_t mk(input logic wr, input logic [31:0] a, input logic [2:0] s,
                               input logic [1:0] t, input logic [63:0] d);
    xfer_t x;
    x.wr = wr; x.addr = a; x.size = s; x.trans = t; x.wdata = d;
    return x;
  endfunction

  // ---------------- pipelined master driver ----------------
  // Entered and left at posedge+1. Results are recorded per queued transfer.
  task automatic run_seq(input bit ws);
    int   a = 0;
    int   pend = -1;
    int   stall = 0;
    logic early = 1'b0;
    int   guard = 0;
    logic rdy, rsp;
    logic [63:0] rd;
    seq_timeout = 1'b0;
    while ((a < q.size() || pend >= 0) && guard < 2000) begin
      guard++;
      if (a < q.size()) begin
        HADDR = q[a].addr; HWRITE = q[a].wr; HSIZE = q[a].size; HTRANS = q[a].trans;
      end else begin
        HADDR = '0; HWRITE = 1'b0; HSIZE = '0; HTRANS = 2'b00;
      end
      HWDATA = (pend >= 0) ? q[pend].wdata : 64'h0;
      @(negedge HCLK);
      rdy = ws ? hready_w : hready_0;
      rsp = ws ? hresp_w : hresp_0;
      rd  = ws ? hrdata_w : hrdata_0;
      if (pend >= 0) begin
        if (rdy) begin
          res_rdata[pend] = rd; res_resp[pend] = rsp;
          res_stall[pend] = stall; res_early[pend] = early;
        end else begin
          stall++;
          early = early | rsp;
        end
      end
      if (rdy) begin
        stall = 0;
        early = 1'b0;
        pend = (a < q.size()) ? a : -1;
        if (a < q.size()) a++;
      end
      @(posedge HCLK);
      #1;
    end
    if (guard >= 2000) seq_timeout = 1'b1;
    HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    HRESETn = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b0;
    @(negedge HCLK);
    checks++; if (hready_0 !== 1'b1) begin errors++; $display("FAIL reset_hready: got %b want 1", hready_0); end
    checks++; if (hresp_0 !== 1'b0) begin errors++; $display("FAIL reset_hresp: got %b want 0", hresp_0); end
    checks++; if (hrdata_0 !== 64'h0) begin errors++; $display("FAIL reset_hrdata: got %h want 0", hrdata_0); end
    checks++; if (hexokay_0 !== 1'b0) begin errors++; $display("FAIL reset_hexokay: got %b want 0", hexokay_0); end
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_write_read();
    q.delete();
    q.push_back(mk(1, 32'h10, 3, 2'b10, 64'h1122334455667788));
    q.push_back(mk(0, 32'h10, 3, 2'b10, 64'h0));
    run_seq(0);
    m_write(32'h10, 3, 64'h1122334455667788);
    checks++; if (seq_timeout) begin errors++; $display("FAIL wr_rd_timeout: got timeout want completion"); end
    checks++; if (res_rdata[1] !== 64'h1122334455667788) begin errors++; $display("FAIL wr_rd_data: got %h want 1122334455667788", res_rdata[1]); end
    checks++; if (res_stall[1] !== 0 || res_resp[1] !== 1'b0) begin errors++; $display("FAIL wr_rd_okay: got stall %0d resp %b want 0 0", res_stall[1], res_resp[1]); end
  endtask

  task automatic test_byte_write();
    q.delete();
    q.push_back(mk(1, 32'h10, 3, 2'b10, 64'h0));
    q.push_back(mk(1, 32'h13, 0, 2'b10, 64'hFFFFFFFF_ABFFFFFF));
    q.push_back(mk(0, 32'h10, 3, 2'b10, 64'h0));
    run_seq(0);
    m_write(32'h10, 3, 64'h0);
    m_write(32'h13, 0, 64'hFFFFFFFF_ABFFFFFF);
    checks++; if (res_rdata[2] !== 64'h00000000AB000000) begin errors++; $display("FAIL byte_write: got %h want 00000000ab000000", res_rdata[2]); end
  endtask

  task automatic test_burst();
    q.delete();
    HBURST = 3'b011;
    for (int i = 0; i < 4; i++)
      q.push_back(mk(1, 32'h20 + 32'(8 * i), 3, (i == 0) ? 2'b10 : 2'b11, 64'(i + 1)));
    for (int i = 0; i < 4; i++)
      q.push_back(mk(0, 32'h20 + 32'(8 * i), 3, (i == 0) ? 2'b10 : 2'b11, 64'h0));
    run_seq(0);
    HBURST = 3'b000;
    for (int i = 0; i < 4; i++) m_write(32'h20 + 32'(8 * i), 3, 64'(i + 1));
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (res_stall[i] !== 0) begin errors++; $display("FAIL burst_stall[%0d]: got %0d want 0", i, res_stall[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res_rdata[4 + i] !== 64'(i + 1)) begin errors++; $display("FAIL burst_rdata[%0d]: got %h want %h", i, res_rdata[4 + i], 64'(i + 1)); end
    end
  endtask

  task automatic test_error();
    q.delete();
    q.push_back(mk(1, 32'h00, 3, 2'b10, 64'hCAFEF00D_DEADBEEF));
    q.push_back(mk(0, 32'h1004, 2, 2'b10, 64'h0));
    q.push_back(mk(0, 32'h0, 0, 2'b00, 64'h0));
    q.push_back(mk(1, 32'h02, 2, 2'b10, 64'hFFFFFFFF_FFFFFFFF));
    q.push_back(mk(1, 32'h00, 4, 2'b10, 64'hFFFFFFFF_FFFFFFFF));
    q.push_back(mk(0, 32'h00, 3, 2'b10, 64'h0));
    run_seq(0);
    m_write(32'h00, 3, 64'hCAFEF00D_DEADBEEF);
    for (int i = 1; i <= 4; i++) begin
      if (i == 2) continue;
      checks++;
      if (res_stall[i] !== 1 || res_early[i] !== 1'b1 || res_resp[i] !== 1'b1) begin
        errors++;
        $display("FAIL error_resp[%0d]: got stall %0d resp %b/%b want 1 1/1", i, res_stall[i], res_early[i], res_resp[i]);
      end
    end
    checks++; if (res_stall[2] !== 0 || res_resp[2] !== 1'b0) begin errors++; $display("FAIL idle_okay: got stall %0d resp %b want 0 0", res_stall[2], res_resp[2]); end
    checks++; if (res_rdata[5] !== m_read(32'h00)) begin errors++; $display("FAIL error_nowrite: got %h want %h", res_rdata[5], m_read(32'h00)); end
  endtask

  task automatic test_reset_abort();
    q.delete();
    q.push_back(mk(1, 32'h40, 3, 2'b10, 64'h0123456789ABCDEF));
    run_seq(0);
    m_write(32'h40, 3, 64'h0123456789ABCDEF);
    HADDR = 32'h40; HWRITE = 1'b1; HSIZE = 3'd3; HTRANS = 2'b10;
    @(posedge HCLK);
    #1;
    HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 64'h5555AAAA5555AAAA; HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    HRESETn = 1'b0;
    q.delete();
    q.push_back(mk(0, 32'h40, 3, 2'b10, 64'h0));
    run_seq(0);
    checks++; if (res_rdata[0] !== m_read(32'h40)) begin errors++; $display("FAIL reset_abort: got %h want %h", res_rdata[0], m_read(32'h40)); end
  endtask

  task automatic test_wait_states();
    q.delete();
    q.push_back(mk(1, 32'h10, 3, 2'b10, 64'h0F0E0D0C0B0A0908));
    q.push_back(mk(0, 32'h10, 3, 2'b10, 64'h0));
    run_seq(1);
    checks++; if (seq_timeout) begin errors++; $display("FAIL ws_timeout: got timeout want completion"); end
    checks++; if (res_stall[1] !== 2 || res_early[1] !== 1'b0 || res_resp[1] !== 1'b0) begin errors++; $display("FAIL ws_stall: got stall %0d resp %b/%b want 2 0/0", res_stall[1], res_early[1], res_resp[1]); end
    checks++; if (res_rdata[1] !== 64'h0F0E0D0C0B0A0908) begin errors++; $display("FAIL ws_rdata: got %h want 0f0e0d0c0b0a0908", res_rdata[1]); end
  endtask

  task automatic test_random();
    logic [63:0] last;
    logic [63:0] exp_d;
    int          exp_stall;
    logic        exp_resp;
    xfer_t       x;
    // Known contents for the random window.
    q.delete();
    for (int i = 0; i < 32; i++) q.push_back(mk(1, 32'(8 * i), 3, 2'b10, 64'h0));
    run_seq(0);
    for (int i = 0; i < 32; i++) m_write(32'(8 * i), 3, 64'h0);
    q.delete();
    q.push_back(mk(0, 32'h0, 3, 2'b10, 64'h0));
    for (int i = 0; i < 120; i++) begin
      logic [31:0] a;
      logic [1:0]  t;
      int unsigned r;
      r = $urandom_range(0, 7);
      t = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 5) ? 2'b10 : 2'b11;
      a = ($urandom_range(0, 7) == 0) ? 32'h1000 + $urandom_range(0, 255)
                                      : 32'($urandom_range(0, 255));
      q.push_back(mk(1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 4)), t,
                     {$urandom, $urandom}));
    end
    run_seq(0);
    checks++; if (seq_timeout) begin errors++; $display("FAIL rand_timeout: got timeout want completion"); end
    last = 64'h0;
    for (int i = 0; i < q.size(); i++) begin
      x = q[i];
      exp_stall = 0; exp_resp = 1'b0;
      if (!x.trans[1]) begin
        exp_d = last;
      end else if (!m_legal(x.addr, x.size)) begin
        exp_stall = 1; exp_resp = 1'b1; exp_d = last;
      end else if (x.wr) begin
        m_write(x.addr, x.size, x.wdata);
        exp_d = last;
      end else begin
        last = m_read(x.addr);
        exp_d = last;
      end
      checks++;
      if (res_stall[i] !== exp_stall || res_resp[i] !== exp_resp || res_early[i] !== exp_resp) begin
        errors++;
        $display("FAIL rand_resp[%0d]: got stall %0d resp %b/%b want %0d %b", i, res_stall[i], res_early[i], res_resp[i], exp_stall, exp_resp);
      end
      checks++;
      if (res_rdata[i] !== exp_d) begin
        errors++;
        $display("FAIL rand_rdata[%0d] addr %h: got %h want %h", i, x.addr, res_rdata[i], exp_d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_write();
    test_burst();
    test_error();
    test_reset_abort();
    test_wait_states();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
